// File: rtl/funct_generator_reader.sv
// Consumer end of the function-generator sample FIFO: pops samples with one-cycle read latency
// and streams them downstream for a programmed burst. Optional peak tracking under PEAK_DETECT_EN.
module funct_generator_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [CNT_W-1:0]      burst_len_i,
  input  logic                  empty_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  rd_en_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_W-1:0]      count_o,
  output logic [DATA_WIDTH-1:0] peak_o
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      len, issued, issued_nxt, count;
  logic                  inflight;
  logic [1:0]            occ, wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem [0:2];
  logic [DATA_WIDTH-1:0] head;
  logic                  push, pop, start_ok;

  assign head     = mem[rd_ptr];
  assign push     = inflight;
  assign pop      = (occ != 2'd0) && ready_i;
  assign start_ok = (state == IDLE) && start_i;

  // Credit rule: buffered plus in-flight samples never exceed the three buffer slots.
  assign rd_en_o = (state == RUN) && !empty_i && (issued < len) &&
                   (({1'b0, occ} + {2'b00, inflight}) < 3'd3);
  assign issued_nxt = issued + CNT_W'(rd_en_o);

  assign valid_o = (occ != 2'd0);
  assign data_o  = valid_o ? head : '0;
  assign busy_o  = (state == RUN) || (state == FLUSH);
  assign done_o  = (state == DONE);
  assign count_o = count;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_i) state_nxt = RUN;
      RUN: begin
        if (len == '0) state_nxt = DONE;
        else if (stop_i || (issued_nxt == len)) state_nxt = FLUSH;
      end
      // Leave as soon as the final pop empties the buffer, so DONE follows the last pop directly.
      FLUSH: if (!inflight && ((occ == 2'd0) || ((occ == 2'd1) && pop))) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      len      <= '0;
      issued   <= '0;
      count    <= '0;
      inflight <= 1'b0;
      occ      <= 2'd0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
    end else begin
      state    <= state_nxt;
      inflight <= rd_en_o;
      if (start_ok) begin
        len    <= burst_len_i;
        issued <= '0;
        count  <= '0;
      end else begin
        if (rd_en_o) issued <= issued_nxt;
        if (pop)     count  <= count + CNT_W'(1);
      end
      if (push) wr_ptr <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
      if (pop)  rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rd_data_i;
  end

`ifdef PEAK_DETECT_EN
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MOST_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  logic [DATA_WIDTH-1:0] peak, mag;

  // The most negative value has no positive twin, so it saturates.
  always_comb begin
    mag = head;
    if (head[DATA_WIDTH-1]) mag = (head == MOST_NEG) ? MOST_POS : -head;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     peak <= '0;
    else if (start_ok)           peak <= '0;
    else if (pop && (mag > peak)) peak <= mag;
  end

  assign peak_o = peak;
`else
  assign peak_o = '0;
`endif

endmodule

// File: tb/tb_funct_generator_reader.sv
// Directed self-checking bench for funct_generator_reader with a behavioural sync-read FIFO.
module tb_funct_generator_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic [15:0] burst_len_i = '0;
  logic        empty_i = 1'b1;
  logic [31:0] rd_data_i = '0;
  logic        rd_en_o;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic        busy_o;
  logic        done_o;
  logic [15:0] count_o;
  logic [31:0] peak_o;

  int checks = 0;
  int failures = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] rx_q[$];
  bit          rd_en_s = 1'b0;
  int          outstanding = 0;
  int          underflow_cnt = 0;
  int          credit_cnt = 0;
  int          stable_cnt = 0;
  int          strobes = 0;
  int          done_cnt = 0;
  bit          stall_prev = 1'b0;
  logic [31:0] stall_data = '0;

  always #5 clk = ~clk;

  funct_generator_reader #(.DATA_WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i),
    .burst_len_i(burst_len_i), .empty_i(empty_i), .rd_data_i(rd_data_i),
    .rd_en_o(rd_en_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .busy_o(busy_o), .done_o(done_o), .count_o(count_o), .peak_o(peak_o)
  );

  // Sync-read FIFO model: data the cycle after the strobe, registered empty flag.
  always @(posedge clk) begin
    if (rd_en_s && fifo_q.size() != 0) rd_data_i <= fifo_q.pop_front();
    empty_i <= (fifo_q.size() == 0);
  end

  // Stream monitor, sampled mid-cycle.
  always @(negedge clk) begin
    rd_en_s = rd_en_o;
    if (rst) begin
      outstanding = 0;
      stall_prev  = 1'b0;
    end else begin
      if (rd_en_o && empty_i) underflow_cnt++;
      if (rd_en_o && outstanding >= 3) credit_cnt++;
      if (stall_prev && (valid_o !== 1'b1 || data_o !== stall_data)) stable_cnt++;
      stall_prev = valid_o && !ready_i;
      stall_data = data_o;
      if (valid_o && ready_i) rx_q.push_back(data_o);
      if (rd_en_o) strobes++;
      if (done_o) done_cnt++;
      outstanding = outstanding + (rd_en_o ? 1 : 0) - ((valid_o && ready_i) ? 1 : 0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_reset;
    fifo_q.delete();
    tick();
    rx_q.delete();
    strobes = 0;
    done_cnt = 0;
    underflow_cnt = 0;
    credit_cnt = 0;
    stable_cnt = 0;
  endtask

  task automatic preload(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + 32'(i));
    tick();
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_o) begin
        timed_out = 1'b0;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (rd_en_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_en got=%b want=0", rd_en_o); end
    checks++; if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b want=0", valid_o); end
    checks++; if (data_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_data got=%h want=0", data_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", busy_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b want=0", done_o); end
    checks++; if (count_o !== 16'h0) begin failures++; $display("[TB] FAIL reset_count got=%0d want=0", count_o); end
    checks++; if (peak_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_peak got=%h want=0", peak_o); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_rate;
    logic [13:0] rd_mask, v_mask, d_mask, b_mask;
    int data_err;
    data_err = 0;
    fifo_reset();
    preload(32'h1, 8);
    ready_i = 1'b1;
    start_i = 1'b1;
    burst_len_i = 16'd8;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      rd_mask[c] = rd_en_o;
      v_mask[c]  = valid_o;
      d_mask[c]  = done_o;
      b_mask[c]  = busy_o;
      if (valid_o && data_o !== 32'(c - 2)) data_err++;
      tick();
      start_i = (c + 1 == 11);
    end
    start_i = 1'b0;
    checks++; if (rd_mask !== 14'h01FE) begin failures++; $display("[TB] FAIL full_rd_en_cycles got=%h want=01fe", rd_mask); end
    checks++; if (v_mask !== 14'h07F8) begin failures++; $display("[TB] FAIL full_valid_cycles got=%h want=07f8", v_mask); end
    checks++; if (d_mask !== 14'h0800) begin failures++; $display("[TB] FAIL full_done_cycle got=%h want=0800", d_mask); end
    checks++; if (b_mask !== 14'h07FE) begin failures++; $display("[TB] FAIL full_busy_cycles got=%h want=07fe", b_mask); end
    checks++; if (data_err !== 0) begin failures++; $display("[TB] FAIL full_data_order bad=%0d want=0", data_err); end
    checks++; if (count_o !== 16'd8) begin failures++; $display("[TB] FAIL full_count got=%0d want=8", count_o); end
  endtask

  task automatic test_backpressure;
    bit timed_out;
    int bad;
    logic [3:0] pattern;
    pattern = 4'b1001;
    bad = 0;
    timed_out = 1'b1;
    fifo_reset();
    preload(32'h1, 8);
    start_i = 1'b1;
    burst_len_i = 16'd8;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 200; i++) begin
      ready_i = pattern[3 - (i % 4)];
      @(negedge clk);
      if (done_o) begin timed_out = 1'b0; break; end
      tick();
    end
    tick();
    ready_i = 1'b1;
    for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== 32'(i + 1)) bad++;
    checks++; if (timed_out) begin failures++; $display("[TB] FAIL bp_timeout got=timeout want=done"); end
    checks++; if (rx_q.size() !== 8 || bad !== 0) begin failures++; $display("[TB] FAIL bp_samples got=%0d(bad %0d) want=8", rx_q.size(), bad); end
    checks++; if (stable_cnt !== 0) begin failures++; $display("[TB] FAIL bp_stall_stable got=%0d want=0", stable_cnt); end
    checks++; if (credit_cnt !== 0) begin failures++; $display("[TB] FAIL bp_credit got=%0d want=0", credit_cnt); end
    checks++; if (count_o !== 16'd8) begin failures++; $display("[TB] FAIL bp_count got=%0d want=8", count_o); end
  endtask

  task automatic test_empty_fifo;
    bit timed_out;
    fifo_reset();
    fifo_q.push_back(32'h11);
    fifo_q.push_back(32'h22);
    tick();
    start_i = 1'b1;
    burst_len_i = 16'd4;
    tick();
    start_i = 1'b0;
    repeat (10) tick();
    fifo_q.push_back(32'h33);
    fifo_q.push_back(32'h44);
    wait_done(50, timed_out);
    checks++; if (timed_out) begin failures++; $display("[TB] FAIL empty_timeout got=timeout want=done"); end
    checks++; if (underflow_cnt !== 0) begin failures++; $display("[TB] FAIL empty_underflow got=%0d want=0", underflow_cnt); end
    checks++; if (rx_q.size() !== 4 || rx_q[0] !== 32'h11 || rx_q[3] !== 32'h44) begin
      failures++; $display("[TB] FAIL empty_samples got=%0d want=4 (11..44)", rx_q.size()); end
    checks++; if (count_o !== 16'd4) begin failures++; $display("[TB] FAIL empty_count got=%0d want=4", count_o); end
  endtask

  task automatic test_abort;
    bit timed_out;
    int bad;
    bad = 0;
    fifo_reset();
    preload(32'h100, 20);
    start_i = 1'b1;
    burst_len_i = 16'd100;
    tick();
    start_i = 1'b0;
    repeat (5) tick();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    wait_done(50, timed_out);
    repeat (5) tick();
    for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== 32'h100 + 32'(i)) bad++;
    checks++; if (timed_out || done_cnt !== 1) begin failures++; $display("[TB] FAIL abort_done got=%0d want=1", done_cnt); end
    checks++; if (rx_q.size() !== 6 || bad !== 0) begin failures++; $display("[TB] FAIL abort_samples got=%0d(bad %0d) want=6", rx_q.size(), bad); end
    checks++; if (strobes !== 6) begin failures++; $display("[TB] FAIL abort_strobes got=%0d want=6", strobes); end
    checks++; if (count_o !== 16'd6) begin failures++; $display("[TB] FAIL abort_count got=%0d want=6", count_o); end
  endtask

  task automatic test_zero_len;
    logic [3:0] d_mask, b_mask;
    fifo_reset();
    preload(32'h5, 4);
    start_i = 1'b1;
    burst_len_i = 16'd0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      d_mask[c] = done_o;
      b_mask[c] = busy_o;
      tick();
      start_i = 1'b0;
    end
    checks++; if (d_mask !== 4'b0100) begin failures++; $display("[TB] FAIL zero_done_cycle got=%b want=0100", d_mask); end
    checks++; if (b_mask !== 4'b0010) begin failures++; $display("[TB] FAIL zero_busy got=%b want=0010", b_mask); end
    checks++; if (strobes !== 0) begin failures++; $display("[TB] FAIL zero_strobes got=%0d want=0", strobes); end
  endtask

  task automatic test_start_busy;
    bit timed_out;
    fifo_reset();
    preload(32'h200, 8);
    start_i = 1'b1;
    burst_len_i = 16'd4;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    start_i = 1'b1;
    burst_len_i = 16'd2;
    tick();
    start_i = 1'b0;
    wait_done(50, timed_out);
    repeat (4) tick();
    checks++; if (timed_out || done_cnt !== 1) begin failures++; $display("[TB] FAIL busy_done got=%0d want=1", done_cnt); end
    checks++; if (rx_q.size() !== 4 || count_o !== 16'd4) begin
      failures++; $display("[TB] FAIL busy_ignored got=%0d/%0d want=4/4", rx_q.size(), count_o); end
  endtask

  task automatic test_reset_mid;
    fifo_reset();
    preload(32'h300, 8);
    ready_i = 1'b0;
    start_i = 1'b1;
    burst_len_i = 16'd8;
    tick();
    start_i = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    checks++; if (rd_en_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_rd_en got=%b want=0", rd_en_o); end
    checks++; if (valid_o !== 1'b0 || data_o !== 32'h0) begin failures++; $display("[TB] FAIL rstmid_stream got=%b/%h want=0/0", valid_o, data_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy got=%b want=0", busy_o); end
    checks++; if (count_o !== 16'h0 || peak_o !== 32'h0) begin failures++; $display("[TB] FAIL rstmid_count_peak got=%0d/%h want=0/0", count_o, peak_o); end
    tick();
    rst = 1'b0;
    ready_i = 1'b1;
    repeat (6) tick();
    checks++; if (done_cnt !== 0 || busy_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_idle got=done%0d/busy%b want=0/0", done_cnt, busy_o); end
  endtask

  task automatic test_peak;
    bit timed_out;
    logic [31:0] want4, want5;
`ifdef PEAK_DETECT_EN
    want4 = 32'h10000000;
    want5 = 32'h7FFFFFFF;
`else
    want4 = 32'h0;
    want5 = 32'h0;
`endif
    fifo_reset();
    fifo_q.push_back(32'h10000000);
    fifo_q.push_back(32'h80000000);
    fifo_q.push_back(32'hF0000000);
    tick();
    start_i = 1'b1;
    burst_len_i = 16'd3;
    tick();
    start_i = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++; if (peak_o !== want4) begin failures++; $display("[TB] FAIL peak_first got=%h want=%h", peak_o, want4); end
    tick();
    @(negedge clk);
    checks++; if (peak_o !== want5) begin failures++; $display("[TB] FAIL peak_saturate got=%h want=%h", peak_o, want5); end
    wait_done(20, timed_out);
    checks++; if (timed_out || peak_o !== want5) begin failures++; $display("[TB] FAIL peak_final got=%h want=%h", peak_o, want5); end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_full_rate();
    test_backpressure();
    test_empty_fifo();
    test_abort();
    test_zero_len();
    test_start_busy();
    test_reset_mid();
    test_peak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
